// File: rtl/sad_accum.sv
// sad_accum -- per-flux sum-of-absolute-differences accumulator.
//
// Sits downstream of the delay actor. Each cycle at most one flux fires:
// one sample is popped from its current-pel FIFO and one from its delayed-pel
// FIFO in the same cycle. |cur - dly| is added into that flux's accumulator.
// When BLOCK_LEN samples have been summed, one {tag, sad} word is pushed to the
// output FIFO in the cycle the last sample is read. FLUX fluxes are
// interleaved with fixed priority, and the lowest index wins.
//
// Build option: SAD_ACCUM_SATURATE_EN
//   defined     -> the accumulator and result clamp to 2**OUT_WIDTH-1
//   not defined -> the accumulator and result wrap modulo 2**OUT_WIDTH
//
// Ports
//   clk                        rising-edge clock
//   rst                        asynchronous, active-high reset
//   read_port_in_cur_empty     per-flux empty flags, current-pel FIFO
//   read_port_in_cur_dout      head word of the flux being popped ({tag, pel})
//   read_port_in_cur_read      one-hot pop, current-pel FIFO
//   read_port_in_dly_empty     per-flux empty flags, delayed-pel FIFO
//   read_port_in_dly_dout      head word of the flux being popped ({tag, pel})
//   read_port_in_dly_read      one-hot pop, delayed-pel FIFO
//   write_port_out_sad_full    per-flux full flags, output FIFO
//   write_port_out_sad_write   push strobe
//   write_port_out_sad_din     {tag, sad}

module sad_accum #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_LEN  = 8,
  parameter int OUT_WIDTH  = 12,
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int CNT_WIDTH = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLUX-1:0]                read_port_in_cur_empty,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] read_port_in_cur_dout,
  output logic [FLUX-1:0]                read_port_in_cur_read,
  input  logic [FLUX-1:0]                read_port_in_dly_empty,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] read_port_in_dly_dout,
  output logic [FLUX-1:0]                read_port_in_dly_read,
  input  logic [FLUX-1:0]                write_port_out_sad_full,
  output logic                           write_port_out_sad_write,
  output logic [TAG_WIDTH+OUT_WIDTH-1:0] write_port_out_sad_din
);

  typedef enum logic {ST_ACC, ST_LAST} flux_state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

  logic [CNT_WIDTH-1:0]  cnt [FLUX];
  logic [OUT_WIDTH-1:0]  acc [FLUX];
  flux_state_t           st  [FLUX];

  logic [FLUX-1:0]       elig;
  logic                  fire;
  logic                  sel_last;
  logic [TAG_WIDTH-1:0]  tag;

  logic [DATA_WIDTH-1:0] cur_pel;
  logic [DATA_WIDTH-1:0] dly_pel;
  logic [DATA_WIDTH-1:0] diff;
  logic [OUT_WIDTH:0]    sum;
  logic [OUT_WIDTH-1:0]  final_sum;
  logic                  unused_bits;

  // The flux state is a pure decode of the sample counter. This keeps the counter
  // as the only stored per-flux control state.
  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      st[f] = (cnt[f] == LAST_CNT) ? ST_LAST : ST_ACC;
    end
  end

  // Eligibility and fixed-priority selection. The loop scans downward so that
  // the lowest eligible index is the last one written. Only a LAST sample waits
  // for output space. Reset forces the block idle without a clock edge.
  always_comb begin
    elig = '0;
    fire = 1'b0;
    tag  = '0;
    for (int f = FLUX - 1; f >= 0; f--) begin
      elig[f] = !read_port_in_cur_empty[f] && !read_port_in_dly_empty[f] &&
                ((st[f] == ST_ACC) || !write_port_out_sad_full[f]);
      if (elig[f]) begin
        fire = 1'b1;
        tag  = TAG_WIDTH'(f);
      end
    end
    if (rst) begin
      fire = 1'b0;
    end
    sel_last = (st[tag] == ST_LAST);
  end

  // Absolute difference and accumulation. The extra carry bit of sum selects
  // between wrap and clamp behaviour.
  always_comb begin
    cur_pel = read_port_in_cur_dout[DATA_WIDTH-1:0];
    dly_pel = read_port_in_dly_dout[DATA_WIDTH-1:0];
    diff    = (cur_pel >= dly_pel) ? (cur_pel - dly_pel) : (dly_pel - cur_pel);
    sum     = {1'b0, acc[tag]} + (OUT_WIDTH+1)'(diff);
`ifdef SAD_ACCUM_SATURATE_EN
    final_sum = sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
`else
    final_sum = sum[OUT_WIDTH-1:0];
`endif
  end

  // The tag fields of the input words are not needed. The flux is already known
  // from the arbiter.
  assign unused_bits = ^{read_port_in_cur_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH],
                         read_port_in_dly_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH],
                         sum[OUT_WIDTH]};

  // Both pops share one strobe, so the two sides of a flux can never drift apart.
  // The result word is presented in the same cycle as the last sample's reads.
  always_comb begin
    read_port_in_cur_read    = fire ? (FLUX'(1) << tag) : '0;
    read_port_in_dly_read    = fire ? (FLUX'(1) << tag) : '0;
    write_port_out_sad_write = fire && sel_last;
    write_port_out_sad_din   = write_port_out_sad_write ? {tag, final_sum} : 'x;
  end

  // Per-flux counter and accumulator. Only the selected flux moves. A LAST fire
  // clears that flux so that its next sample starts a fresh block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        cnt[f] <= '0;
        acc[f] <= '0;
      end
    end else if (fire) begin
      if (sel_last) begin
        cnt[tag] <= '0;
        acc[tag] <= '0;
      end else begin
        cnt[tag] <= cnt[tag] + CNT_WIDTH'(1);
        acc[tag] <= final_sum;
      end
    end
  end

endmodule
